// File: rtl/mem_arb.sv
// Two-to-one arbiter sharing one ram between the instruction and data ports.
// Data port has fixed priority; each port holds at most one pending request.
module mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_rstrb,
    output logic [DW-1:0]     i_rdata,
    output logic              i_rbusy,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_wmask,
    input  logic              d_rstrb,
    input  logic              d_wstrb,
    output logic [DW-1:0]     d_rdata,
    output logic              d_rbusy,
    output logic              d_wbusy,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wmask,
    output logic              m_rstrb,
    output logic              m_wstrb,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_rbusy,
    input  logic              m_wbusy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              i_pend_q, i_pend_d;
    logic [AW-1:0]     i_addr_q, i_addr_d;
    logic              d_pend_q, d_pend_d;
    logic              d_we_q, d_we_d;
    logic [AW-1:0]     d_addr_q, d_addr_d;
    logic [DW-1:0]     d_wdata_q, d_wdata_d;
    logic [DW/8-1:0]   d_wmask_q, d_wmask_d;
    logic [DW-1:0]     i_rdata_q, i_rdata_d;
    logic [DW-1:0]     d_rdata_q, d_rdata_d;
    logic [AW-1:0]     m_addr_q, m_addr_d;
    logic [DW-1:0]     m_wdata_q, m_wdata_d;
    logic [DW/8-1:0]   m_wmask_q, m_wmask_d;
    logic              m_rstrb_q, m_rstrb_d;
    logic              m_wstrb_q, m_wstrb_d;
    logic              mem_busy, i_done, d_done, rem_i, rem_d, launch;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        i_pend_d  = i_pend_q;
        i_addr_d  = i_addr_q;
        d_pend_d  = d_pend_q;
        d_we_d    = d_we_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_wmask_d = d_wmask_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wmask_d = m_wmask_q;
        m_rstrb_d = 1'b0;
        m_wstrb_d = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        mem_busy  = (gnt_q && d_we_q) ? m_wbusy : m_rbusy;

        case (state_q)
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!mem_busy) begin
                    i_done  = !gnt_q;
                    d_done  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests still pending once the current completion is retired
        rem_i  = i_pend_q && !i_done;
        rem_d  = d_pend_q && !d_done;
        launch = (state_q == IDLE || (state_q == WAIT && !mem_busy))
                 && (rem_i || rem_d);

        if (launch) begin
            state_d = ISSUE;
            gnt_d   = rem_d;
            if (rem_d) begin
                m_addr_d  = d_addr_q;
                m_wdata_d = d_wdata_q;
                m_wmask_d = d_wmask_q;
                m_wstrb_d = d_we_q;
                m_rstrb_d = !d_we_q;
            end else begin
                m_addr_d  = i_addr_q;
                m_rstrb_d = 1'b1;
            end
        end

        if (i_done) begin
            i_pend_d  = 1'b0;
            i_rdata_d = m_rdata;
        end
        if (d_done) begin
            d_pend_d = 1'b0;
            if (!d_we_q) d_rdata_d = m_rdata;
        end

        if (!i_pend_q && i_rstrb) begin
            i_pend_d = 1'b1;
            i_addr_d = i_addr;
        end
        // A write wins over a simultaneous read strobe
        if (!d_pend_q && (d_rstrb || d_wstrb)) begin
            d_pend_d  = 1'b1;
            d_we_d    = d_wstrb;
            d_addr_d  = d_addr;
            d_wdata_d = d_wdata;
            d_wmask_d = d_wmask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            i_pend_q  <= 1'b0;
            i_addr_q  <= '0;
            d_pend_q  <= 1'b0;
            d_we_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_wmask_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wmask_q <= '0;
            m_rstrb_q <= 1'b0;
            m_wstrb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            i_pend_q  <= i_pend_d;
            i_addr_q  <= i_addr_d;
            d_pend_q  <= d_pend_d;
            d_we_q    <= d_we_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_wmask_q <= d_wmask_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wmask_q <= m_wmask_d;
            m_rstrb_q <= m_rstrb_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign i_rbusy = i_pend_q;
    assign d_rdata = d_rdata_q;
    assign d_rbusy = d_pend_q && !d_we_q;
    assign d_wbusy = d_pend_q && d_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wmask = m_wmask_q;
    assign m_rstrb = m_rstrb_q;
    assign m_wstrb = m_wstrb_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small behavioural ram whose busy
// time is set per test.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_addr = '0;
    logic        i_rstrb = 1'b0;
    logic [31:0] i_rdata;
    logic        i_rbusy;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_rstrb = 1'b0;
    logic        d_wstrb = 1'b0;
    logic [31:0] d_rdata;
    logic        d_rbusy, d_wbusy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wmask;
    logic        m_rstrb, m_wstrb, m_rbusy, m_wbusy;

    int checks = 0;
    int errors = 0;
    int k = 0;

    mem_arb #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rstrb(i_rstrb), .i_rdata(i_rdata), .i_rbusy(i_rbusy),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rstrb(d_rstrb), .d_wstrb(d_wstrb), .d_rdata(d_rdata),
        .d_rbusy(d_rbusy), .d_wbusy(d_wbusy),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_rstrb(m_rstrb), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .m_rbusy(m_rbusy), .m_wbusy(m_wbusy)
    );

    always #5 clk = ~clk;

    // Behavioural ram: busy for k cycles after a strobe, data valid after
    logic [31:0] mem [0:255];
    logic [31:0] ram_addr;
    int          ram_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_cnt  <= 0;
            ram_addr <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[4]   <= 32'h0000_0013;
            mem[8]   <= 32'h1111_2222;
            mem[128] <= 32'h3333_4444;
        end else if (m_rstrb || m_wstrb) begin
            ram_addr <= m_addr;
            ram_cnt  <= k;
            if (m_wstrb)
                for (int b = 0; b < 4; b++)
                    if (m_wmask[b]) mem[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
        end else if (ram_cnt > 0) begin
            ram_cnt <= ram_cnt - 1;
        end
    end

    assign m_rbusy = (ram_cnt > 0);
    assign m_wbusy = (ram_cnt > 0);
    assign m_rdata = mem[ram_addr[9:2]];

    // Strobe log on the shared port
    logic [31:0] rlog [0:63];
    int n_r = 0;
    int n_w = 0;

    always @(posedge clk) begin
        if (m_rstrb) begin
            rlog[n_r % 64] <= m_addr;
            n_r <= n_r + 1;
        end
        if (m_wstrb) n_w <= n_w + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((i_rbusy || d_rbusy || d_wbusy) && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    int r0, w0;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_i_rbusy", 32'(i_rbusy), 0);
        check("rst_d_busy", {30'd0, d_rbusy, d_wbusy}, 0);
        check("rst_m_strb", {30'd0, m_rstrb, m_wstrb}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wmask", 32'(m_wmask), 0);

        // Uncontended instruction read, k=0
        k = 0;
        r0 = n_r;
        i_addr = 32'h10; i_rstrb = 1'b1;
        step();
        i_rstrb = 1'b0;
        check("t1_c1_i_rbusy", 32'(i_rbusy), 1);
        check("t1_c1_m_rstrb", 32'(m_rstrb), 0);
        step();
        check("t1_c2_m_rstrb", 32'(m_rstrb), 1);
        check("t1_c2_m_addr", m_addr, 32'h10);
        step();
        check("t1_c3_i_rbusy", 32'(i_rbusy), 1);
        check("t1_c3_m_rstrb", 32'(m_rstrb), 0);
        step();
        check("t1_c4_i_rbusy", 32'(i_rbusy), 0);
        check("t1_c4_i_rdata", i_rdata, 32'h13);

        // Masked write then read-back
        d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        d_wstrb = 1'b1;
        step();
        d_wstrb = 1'b0;
        check("t2_wbusy", 32'(d_wbusy), 1);
        check("t2_rbusy", 32'(d_rbusy), 0);
        wait_idle("t2_w_timeout");
        check("t2_d_rdata_held", d_rdata, 0);
        d_rstrb = 1'b1;
        step();
        d_rstrb = 1'b0;
        check("t2_rbusy_rd", 32'(d_rbusy), 1);
        wait_idle("t2_r_timeout");
        check("t2_d_rdata", d_rdata, 32'h0000BEEF);
        check("t2_i_rdata_held", i_rdata, 32'h13);

        // Simultaneous instruction and data reads, k=2
        k = 2;
        r0 = n_r;
        i_addr = 32'h20; i_rstrb = 1'b1;
        d_addr = 32'h200; d_rstrb = 1'b1;
        step();
        i_rstrb = 1'b0; d_rstrb = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 9) check($sformatf("t3_c%0d_i_rbusy", c), 32'(i_rbusy), 1);
            case (c)
                2: begin
                    check("t3_c2_m_rstrb", 32'(m_rstrb), 1);
                    check("t3_c2_m_addr", m_addr, 32'h200);
                end
                5: check("t3_c5_d_rbusy", 32'(d_rbusy), 1);
                6: begin
                    check("t3_c6_d_rbusy", 32'(d_rbusy), 0);
                    check("t3_c6_d_rdata", d_rdata, 32'h3333_4444);
                    check("t3_c6_m_rstrb", 32'(m_rstrb), 1);
                    check("t3_c6_m_addr", m_addr, 32'h20);
                end
                10: begin
                    check("t3_c10_i_rbusy", 32'(i_rbusy), 0);
                    check("t3_c10_i_rdata", i_rdata, 32'h1111_2222);
                end
                default: ;
            endcase
            if (c < 10) step();
        end
        check("t3_nreads", 32'(n_r - r0), 2);
        check("t3_order0", rlog[r0 % 64], 32'h200);
        check("t3_order1", rlog[(r0 + 1) % 64], 32'h20);

        // Repeat strobe while busy is ignored, k=3
        k = 3;
        r0 = n_r;
        i_addr = 32'h10; i_rstrb = 1'b1;
        step();
        i_rstrb = 1'b0;
        step();
        i_addr = 32'h20; i_rstrb = 1'b1;
        step();
        i_rstrb = 1'b0; i_addr = 32'h0;
        wait_idle("t4_timeout");
        step();
        check("t4_nreads", 32'(n_r - r0), 1);
        check("t4_i_rdata", i_rdata, 32'h13);

        // Simultaneous read and write strobes: write wins
        k = 0;
        r0 = n_r;
        w0 = n_w;
        d_addr = 32'h104; d_wdata = 32'hA5A5A5A5; d_wmask = 4'hF;
        d_rstrb = 1'b1; d_wstrb = 1'b1;
        step();
        d_rstrb = 1'b0; d_wstrb = 1'b0;
        check("t5_wbusy", 32'(d_wbusy), 1);
        check("t5_rbusy", 32'(d_rbusy), 0);
        step();
        check("t5_m_wstrb", 32'(m_wstrb), 1);
        check("t5_m_rstrb", 32'(m_rstrb), 0);
        wait_idle("t5_timeout");
        step();
        check("t5_nwrites", 32'(n_w - w0), 1);
        check("t5_nreads", 32'(n_r - r0), 0);
        check("t5_d_rdata_held", d_rdata, 32'h3333_4444);

        // Reset during WAIT, k=5
        k = 5;
        i_addr = 32'h10; i_rstrb = 1'b1;
        step();
        i_rstrb = 1'b0;
        repeat (3) step();
        check("t6_pre_i_rbusy", 32'(i_rbusy), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_i_rbusy", 32'(i_rbusy), 0);
        check("t6_rst_strb", {30'd0, m_rstrb, m_wstrb}, 0);
        check("t6_rst_i_rdata", i_rdata, 0);
        step();
        rst = 1'b0;
        r0 = n_r;
        w0 = n_w;
        repeat (8) step();
        check("t6_no_strb", 32'((n_r - r0) + (n_w - w0)), 0);
        k = 0;
        i_rstrb = 1'b1;
        step();
        i_rstrb = 1'b0;
        check("t6_fresh_busy", 32'(i_rbusy), 1);
        wait_idle("t6_timeout");
        check("t6_fresh_rdata", i_rdata, 32'h13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
